// File: rtl/sram_uart_dumper.sv
// sram_uart_dumper
//   Streams a block of 16-bit SRAM words out of a UART 8N1 transmitter. Each
//   word goes out high byte first, then low byte. Frames are sent back-to-back.
//   The word after the current one is read while the low byte is on the line,
//   so the stream never pauses for SRAM latency.
//
//   Optional feature macro: PPM_HEADER_EN. When it is defined, a 15-byte ASCII
//   PPM header ("P6\n320 240\n255\n") is sent before the data, even when
//   Num_words is 0.
//
// Ports
//   Clock_50        in   system clock
//   Resetn          in   synchronous active-low reset
//   Start           in   1-cycle pulse; begins a dump when idle
//   Base_address    in   first SRAM word address, sampled on Start
//   Num_words       in   number of words to send, sampled on Start
//   SRAM_address    out  word address being read (holds its value while idle)
//   SRAM_we_n       out  constant 1; this block only reads
//   SRAM_read_data  in   read data, SRAM_RD_LAT cycles after the address
//   UART_TX_O       out  serial output, idles high
//   Busy            out  high while the dump owns the SRAM port
//   Done            out  1-cycle pulse after the final stop bit
module sram_uart_dumper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SRAM_RD_LAT  = 2
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [17:0] Num_words,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LAT_W = (SRAM_RD_LAT > 0) ? $clog2(SRAM_RD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRAM_RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
`ifdef PPM_HEADER_EN
    S_HEADER = 3'd1,
`endif
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_TX_HI  = 3'd4,
    S_TX_LO  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

`ifdef PPM_HEADER_EN
  localparam logic [3:0] HDR_LAST = 4'd14;

  function automatic logic [7:0] hdr_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_rom = "P";
      4'd1:    hdr_rom = "6";
      4'd2:    hdr_rom = 8'h0A;
      4'd3:    hdr_rom = "3";
      4'd4:    hdr_rom = "2";
      4'd5:    hdr_rom = "0";
      4'd6:    hdr_rom = " ";
      4'd7:    hdr_rom = "2";
      4'd8:    hdr_rom = "4";
      4'd9:    hdr_rom = "0";
      4'd10:   hdr_rom = 8'h0A;
      4'd11:   hdr_rom = "2";
      4'd12:   hdr_rom = "5";
      4'd13:   hdr_rom = "5";
      default: hdr_rom = 8'h0A;
    endcase
  endfunction

  logic [3:0] hdr_idx;
`endif

  state_t           state;
  logic [17:0]      addr;       // address of the word currently in word_buf
  logic [17:0]      remaining;  // words still to send, including the current one
  logic [15:0]      word_buf;
  logic [15:0]      next_buf;   // prefetched next word
  logic [LAT_W-1:0] lat_cnt;
  logic             pf_busy;
  logic [LAT_W-1:0] pf_cnt;

  // Serializer: shift[0] is the bit on the line. Ones are shifted in from the top.
  logic [9:0]       shift;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] clk_cnt;

  logic       in_tx, bit_tick, frame_end;
  logic       load_en;
  logic [7:0] load_byte;

  assign SRAM_we_n = 1'b1;

  assign bit_tick  = (clk_cnt == BIT_LAST);
  assign frame_end = in_tx && bit_tick && (bit_idx == 4'd9);

  // Decide when a new frame starts and which byte it carries. A new frame
  // loads on the same edge that ends the previous stop bit, so no idle
  // cycle appears between frames.
  always_comb begin
    in_tx     = 1'b0;
    load_en   = 1'b0;
    load_byte = 8'h00;
    case (state)
`ifdef PPM_HEADER_EN
      S_IDLE: if (Start) begin
        load_en   = 1'b1;
        load_byte = hdr_rom(4'd0);
      end
      S_HEADER: begin
        in_tx = 1'b1;
        if (frame_end) begin
          if (hdr_idx != HDR_LAST) begin
            load_en   = 1'b1;
            load_byte = hdr_rom(hdr_idx + 4'd1);
          end else if (remaining != 18'd0) begin
            load_en   = 1'b1;
            load_byte = next_buf[15:8];
          end
        end
      end
`endif
      S_WAIT: if (lat_cnt == LAT_LAST) begin
        load_en   = 1'b1;
        load_byte = SRAM_read_data[15:8];
      end
      S_TX_HI: begin
        in_tx = 1'b1;
        if (frame_end) begin
          load_en   = 1'b1;
          load_byte = word_buf[7:0];
        end
      end
      S_TX_LO: begin
        in_tx = 1'b1;
        if (frame_end && remaining != 18'd1) begin
          load_en   = 1'b1;
          load_byte = next_buf[15:8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      addr         <= '0;
      remaining    <= '0;
      word_buf     <= '0;
      next_buf     <= '0;
      lat_cnt      <= '0;
      pf_busy      <= 1'b0;
      pf_cnt       <= '0;
      shift        <= '1;
      bit_idx      <= '0;
      clk_cnt      <= '0;
      SRAM_address <= '0;
      UART_TX_O    <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
`ifdef PPM_HEADER_EN
      hdr_idx      <= '0;
`endif
    end else begin
      Done <= 1'b0;

      // Background read of the next word. A kick below overrides this.
      if (pf_busy) begin
        if (pf_cnt == LAT_LAST) begin
          next_buf <= SRAM_read_data;
          pf_busy  <= 1'b0;
        end else begin
          pf_cnt <= pf_cnt + 1'b1;
        end
      end

      // Serializer
      if (load_en) begin
        shift     <= {1'b1, load_byte, 1'b0};
        UART_TX_O <= 1'b0;
        bit_idx   <= '0;
        clk_cnt   <= '0;
      end else if (in_tx) begin
        if (bit_tick) begin
          clk_cnt <= '0;
          if (bit_idx != 4'd9) begin
            bit_idx   <= bit_idx + 4'd1;
            shift     <= {1'b1, shift[9:1]};
            UART_TX_O <= shift[1];
          end else begin
            UART_TX_O <= 1'b1;
          end
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: if (Start) begin
          addr      <= Base_address;
          remaining <= Num_words;
          Busy      <= 1'b1;
`ifdef PPM_HEADER_EN
          // The first data word is read while the header goes out.
          hdr_idx <= '0;
          state   <= S_HEADER;
          if (Num_words != 18'd0) begin
            SRAM_address <= Base_address;
            pf_cnt       <= '0;
            pf_busy      <= 1'b1;
          end
`else
          if (Num_words == 18'd0) begin
            Done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            state <= S_ISSUE;
          end
`endif
        end
`ifdef PPM_HEADER_EN
        S_HEADER: if (frame_end) begin
          if (hdr_idx != HDR_LAST) begin
            hdr_idx <= hdr_idx + 4'd1;
          end else if (remaining == 18'd0) begin
            Done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            word_buf <= next_buf;
            state    <= S_TX_HI;
          end
        end
`endif
        S_ISSUE: begin
          SRAM_address <= addr;
          lat_cnt      <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            word_buf <= SRAM_read_data;
            state    <= S_TX_HI;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_TX_HI: if (frame_end) begin
          state <= S_TX_LO;
          // Read the next word while the low byte is on the line. The read
          // must finish within one frame (10*CLKS_PER_BIT > SRAM_RD_LAT+1).
          if (remaining != 18'd1) begin
            SRAM_address <= addr + 18'd1;
            pf_cnt       <= '0;
            pf_busy      <= 1'b1;
          end
        end
        S_TX_LO: if (frame_end) begin
          addr      <= addr + 18'd1;  // wraps modulo 2^18
          remaining <= remaining - 18'd1;
          if (remaining == 18'd1) begin
            Done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            word_buf <= next_buf;
            state    <= S_TX_HI;
          end
        end
        S_FINISH: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_dumper.sv
// Bench for sram_uart_dumper with CLKS_PER_BIT=4 and SRAM_RD_LAT=2.
// It models the SRAM as a 2-stage read pipeline and decodes the UART line at mid-bit.
module tb_sram_uart_dumper;
  localparam int CPB = 4;
  localparam int LAT = 2;
  localparam int FRAME = 10 * CPB;
`ifdef PPM_HEADER_EN
  localparam int HDR_N = 15;
`else
  localparam int HDR_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] base_in = '0;
  logic [17:0] num_in = '0;
  logic [17:0] sram_addr;
  logic        we_n, tx, busy, done;
  logic [15:0] rdata = '0;
  logic [15:0] d1 = '0;

  logic [15:0] mem [int];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  bit          we_low = 1'b0;
  int          frame_err = 0;
  logic [7:0]  rx_q [$];
  int          rx_cyc [$];
  string       hdr = "P6\n320 240\n255\n";

  typedef struct {
    logic [17:0]       base;
    logic [17:0]       num;
    logic [0:3][15:0]  data;      // words at base, base+1, ...
    logic [0:7][7:0]   exp;       // expected data bytes in line order
    int                n_exp;
    logic [17:0]       last_addr; // SRAM_address expected once idle again
    bit                restart;   // pulse Start again in the middle of the dump
  } vec_t;
  vec_t vecs [5];

  sram_uart_dumper #(.CLKS_PER_BIT(CPB), .SRAM_RD_LAT(LAT)) dut (
    .Clock_50(clk), .Resetn(rst_n), .Start(start),
    .Base_address(base_in), .Num_words(num_in),
    .SRAM_address(sram_addr), .SRAM_we_n(we_n), .SRAM_read_data(rdata),
    .UART_TX_O(tx), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [17:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    d1    <= rd(sram_addr);
    rdata <= d1;
  end

  always @(negedge clk) begin
    if (we_n !== 1'b1) we_low <= 1'b1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // UART receiver. It detects the start bit at the negedge of its first
  // cycle and samples each later bit in the middle of that bit.
  initial begin : uart_rx
    logic [7:0] b;
    int         sc;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        sc = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(b);
        rx_cyc.push_back(sc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k);
    vec_t       v;
    logic [7:0] exp_q [$];
    int         c, budget, dcyc;
    bit         busy_ok, seen, gap_ok;
    v = vecs[k];
    for (int i = 0; i < int'(v.num); i++) mem[int'(18'(v.base + 18'(i)))] = v.data[i];
    for (int i = 0; i < HDR_N; i++) exp_q.push_back(hdr[i]);
    for (int i = 0; i < v.n_exp; i++) exp_q.push_back(v.exp[i]);
    rx_q.delete();
    rx_cyc.delete();

    @(negedge clk);
    start = 1'b1; base_in = v.base; num_in = v.num;
    @(negedge clk);
    start = 1'b0;
    budget = exp_q.size() * FRAME + 60;
    busy_ok = 1'b1; seen = 1'b0; dcyc = 0;
    for (c = 0; c < budget; c++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
      @(negedge clk);
      // An ignored Start that carries different base and count
      start   = v.restart && (c == 20);
      base_in = start ? 18'h00200 : v.base;
      num_in  = start ? 18'd5 : v.num;
    end
    start = 1'b0;
    chk($sformatf("v%0d done_seen", k), 32'(seen), 1);
    chk($sformatf("v%0d busy_until_done", k), 32'(busy_ok), 1);
    if (exp_q.size() == 0)
      chk($sformatf("v%0d done_within_3", k), 32'(c < 3), 1);
    else if (seen && rx_cyc.size() > 0)
      chk($sformatf("v%0d done_latency", k), 32'(dcyc - rx_cyc[0]), 32'(exp_q.size() * FRAME));
    @(negedge clk);
    chk($sformatf("v%0d done_single", k), 32'(done), 0);
    chk($sformatf("v%0d busy_low_after", k), 32'(busy), 0);
    repeat (FRAME + 5) @(negedge clk);
    chk($sformatf("v%0d byte_count", k), 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("v%0d byte%0d", k, i), 32'(rx_q[i]), 32'(exp_q[i]));
    gap_ok = 1'b1;
    for (int i = 1; i < rx_cyc.size(); i++)
      if (rx_cyc[i] - rx_cyc[i-1] != FRAME) gap_ok = 1'b0;
    chk($sformatf("v%0d no_gap", k), 32'(gap_ok), 1);
    chk($sformatf("v%0d sram_addr_hold", k), 32'(sram_addr), 32'(v.last_addr));
  endtask

  initial begin
    int c, dc0;
    vecs[0] = '{base: 18'h00100, num: 18'd1, data: 64'hA55A_0000_0000_0000,
                exp: 64'hA55A_0000_0000_0000, n_exp: 2, last_addr: 18'h00100, restart: 1'b1};
    vecs[1] = '{base: 18'h3FFFF, num: 18'd2, data: 64'h1234_5678_0000_0000,
                exp: 64'h1234_5678_0000_0000, n_exp: 4, last_addr: 18'h00000, restart: 1'b0};
    vecs[2] = '{base: 18'h00200, num: 18'd3, data: 64'h0001_FF00_8081_0000,
                exp: 64'h0001_FF00_8081_0000, n_exp: 6, last_addr: 18'h00202, restart: 1'b0};
    vecs[3] = '{base: 18'h00010, num: 18'd0, data: 64'h0,
                exp: 64'h0, n_exp: 0, last_addr: 18'h00202, restart: 1'b0};
    vecs[4] = '{base: 18'h3FFFE, num: 18'd4, data: 64'h0A0B_0C0D_0E0F_1011,
                exp: 64'h0A0B_0C0D_0E0F_1011, n_exp: 8, last_addr: 18'h00001, restart: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst we_n", 32'(we_n), 1);
    chk("rst sram_addr", 32'(sram_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Reset during the 3rd data bit of the first frame. High byte 0x5A has d2=0.
    mem[int'(18'h00300)] = 16'h5A00;
    @(negedge clk);
    start = 1'b1; base_in = 18'h00300; num_in = 18'd1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (tx !== 1'b0 && c < 60 + HDR_N * FRAME) begin
      @(negedge clk);
      c++;
    end
`ifdef PPM_HEADER_EN
    // Skip the header. Reset lands in the first header frame instead.
`endif
    chk("mid rst start_bit_seen", 32'(tx === 1'b0), 1);
    repeat (3 * CPB + 1) @(negedge clk);
`ifndef PPM_HEADER_EN
    chk("mid rst pre d2_low", 32'(tx), 0);
`endif
    dc0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst tx", 32'(tx), 1);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    chk("mid rst no_done", 32'(done_cnt - dc0), 0);
    chk("mid rst tx_idle", 32'(tx), 1);
    frame_err = 0;  // the truncated frame may be seen as a malformed byte

    // A new dump after the reset
    run_vec(1);

    chk("we_n never low", 32'(we_low), 0);
    chk("framing errors", 32'(frame_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
